// File: rtl/ldpc_mem_bank_array.sv
// Multi-bank simple dual-port message store for the LDPC decoder, with a
// configurable read pipeline, optional write-to-read forwarding and a zero-fill sweep.
module ldpc_mem_bank_array #(
  parameter int pBANK_N = 4,
  parameter int pADDR_W = 8,
  parameter int pDAT_W  = 8,
  parameter int pRD_LAT = 2,
  parameter int pBYPASS = 0
) (
  input  logic                        iclk,
  input  logic                        ireset,
  input  logic                        iclkena,
  input  logic                        iclear,
  output logic                        obusy,
  input  logic [pBANK_N-1:0]          iwrite,
  input  logic [pBANK_N*pADDR_W-1:0]  iwaddr,
  input  logic [pBANK_N*pDAT_W-1:0]   iwdat,
  input  logic                        iread,
  input  logic [pBANK_N*pADDR_W-1:0]  iraddr,
  output logic [pBANK_N*pDAT_W-1:0]   ordat,
  output logic                        ordval
);

  localparam int DEPTH = 1 << pADDR_W;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [pADDR_W-1:0] CNT_LAST = '1;

  logic [0:0]         state_q, state_d;
  logic [pADDR_W-1:0] cnt_q, cnt_d;
  logic [pRD_LAT-1:0] vld_q;

  // The counter wraps to 0 on the same edge the FSM leaves CLEAR, so it
  // never addresses word 0 a second time within one sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iclear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign obusy = (state_q == ST_CLEAR);

  // Read strobe/valid: iread is sampled on every enabled edge while idle; ordval is
  // that strobe exactly pRD_LAT enabled edges later, aligned with its ordat word.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      vld_q <= '0;
    end else if (iclkena) begin
      vld_q[0] <= iread & ~obusy;
      for (int i = 1; i < pRD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign ordval = vld_q[pRD_LAT-1];

  for (genvar b = 0; b < pBANK_N; b++) begin : g_bank
    logic [pDAT_W-1:0]  mem_q [DEPTH];
    logic [pDAT_W-1:0]  pipe_q [pRD_LAT];
    logic [pADDR_W-1:0] waddr, raddr, wr_addr;
    logic [pDAT_W-1:0]  wdat, wr_data, rd_word;
    logic               wr_en;

    assign waddr   = iwaddr[b*pADDR_W +: pADDR_W];
    assign raddr   = iraddr[b*pADDR_W +: pADDR_W];
    assign wdat    = iwdat[b*pDAT_W +: pDAT_W];
    assign wr_en   = obusy | iwrite[b];
    assign wr_addr = obusy ? cnt_q : waddr;
    assign wr_data = obusy ? '0 : wdat;

    always_ff @(posedge iclk) begin
      if (!ireset && iclkena && wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
      rd_word = mem_q[raddr];
      if (pBYPASS != 0 && iwrite[b] && !obusy && (waddr == raddr)) rd_word = wdat;
    end

    always_ff @(posedge iclk) begin
      if (ireset) begin
        for (int i = 0; i < pRD_LAT; i++) pipe_q[i] <= '0;
      end else if (iclkena) begin
        pipe_q[0] <= rd_word;
        for (int i = 1; i < pRD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign ordat[b*pDAT_W +: pDAT_W] = pipe_q[pRD_LAT-1];
  end

endmodule

// File: tb/tb_ldpc_mem_bank_array.sv
// Directed bench: five instances (latency 2 with/without forwarding, latency 1, 3, 4)
// share one stimulus stream and are checked against hand-computed values.
module tb_ldpc_mem_bank_array;

  localparam int ND = 5;

  logic        clk = 1'b0;
  logic        rst, clkena, clear, read;
  logic [3:0]  write;
  logic [15:0] waddr, raddr;
  logic [31:0] wdat;

  logic [ND-1:0] busy_w, rdval_w;
  logic [31:0]   rdat_w [ND];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ldpc_mem_bank_array #(.pBANK_N(4), .pADDR_W(4), .pDAT_W(8), .pRD_LAT(2), .pBYPASS(0)) u_l2 (
    .iclk(clk), .ireset(rst), .iclkena(clkena), .iclear(clear), .obusy(busy_w[0]),
    .iwrite(write), .iwaddr(waddr), .iwdat(wdat), .iread(read), .iraddr(raddr),
    .ordat(rdat_w[0]), .ordval(rdval_w[0]));
  ldpc_mem_bank_array #(.pBANK_N(4), .pADDR_W(4), .pDAT_W(8), .pRD_LAT(2), .pBYPASS(1)) u_l2b (
    .iclk(clk), .ireset(rst), .iclkena(clkena), .iclear(clear), .obusy(busy_w[1]),
    .iwrite(write), .iwaddr(waddr), .iwdat(wdat), .iread(read), .iraddr(raddr),
    .ordat(rdat_w[1]), .ordval(rdval_w[1]));
  ldpc_mem_bank_array #(.pBANK_N(4), .pADDR_W(4), .pDAT_W(8), .pRD_LAT(1), .pBYPASS(0)) u_l1 (
    .iclk(clk), .ireset(rst), .iclkena(clkena), .iclear(clear), .obusy(busy_w[2]),
    .iwrite(write), .iwaddr(waddr), .iwdat(wdat), .iread(read), .iraddr(raddr),
    .ordat(rdat_w[2]), .ordval(rdval_w[2]));
  ldpc_mem_bank_array #(.pBANK_N(4), .pADDR_W(4), .pDAT_W(8), .pRD_LAT(3), .pBYPASS(0)) u_l3 (
    .iclk(clk), .ireset(rst), .iclkena(clkena), .iclear(clear), .obusy(busy_w[3]),
    .iwrite(write), .iwaddr(waddr), .iwdat(wdat), .iread(read), .iraddr(raddr),
    .ordat(rdat_w[3]), .ordval(rdval_w[3]));
  ldpc_mem_bank_array #(.pBANK_N(4), .pADDR_W(4), .pDAT_W(8), .pRD_LAT(4), .pBYPASS(0)) u_l4 (
    .iclk(clk), .ireset(rst), .iclkena(clkena), .iclear(clear), .obusy(busy_w[4]),
    .iwrite(write), .iwaddr(waddr), .iwdat(wdat), .iread(read), .iraddr(raddr),
    .ordat(rdat_w[4]), .ordval(rdval_w[4]));

  function automatic int lat(input int d);
    case (d)
      2:       return 1;
      3:       return 3;
      4:       return 4;
      default: return 2;
    endcase
  endfunction

  // Word stored at address a: bank b holds {a, 2'b00, b}.
  function automatic logic [31:0] pat_word(input int a);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[b*8 +: 8] = {4'(a), 2'b00, 2'(b)};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_all(input logic [3:0] a, input logic [31:0] d);
    write = 4'hF;
    waddr = {4{a}};
    wdat  = d;
    tick();
    write = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clkena = 1'b0; clear = 1'b0; read = 1'b0; write = 4'h0;
    waddr = '0; raddr = '0; wdat = '0;
    tick();
    tick();
    for (int d = 0; d < ND; d++) begin
      n_vec++;
      if (busy_w[d] !== 1'b0 || rdval_w[d] !== 1'b0 || rdat_w[d] !== 32'h0) begin
        n_err++;
        $display("FAIL reset dut%0d: busy=%b val=%b dat=%h, want 0/0/0", d, busy_w[d], rdval_w[d], rdat_w[d]);
      end
    end
    rst = 1'b0; clkena = 1'b1;
  endtask

  task automatic test_read_latency();
    wr_all(4'd3, 32'h13121110);
    wr_all(4'd4, 32'h23222120);
    raddr = {4{4'd3}};
    read = 1'b1;
    tick();
    read = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      for (int d = 0; d < ND; d++) begin
        n_vec++;
        if (rdval_w[d] !== (k == lat(d))) begin
          n_err++;
          $display("FAIL latency_val dut%0d cyc%0d: got %b want %b", d, k, rdval_w[d], k == lat(d));
        end
        if (k == lat(d)) begin
          n_vec++;
          if (rdat_w[d] !== 32'h13121110) begin
            n_err++;
            $display("FAIL latency_dat dut%0d: got %h want 13121110", d, rdat_w[d]);
          end
        end
      end
    end
  endtask

  task automatic test_clkena_stall();
    raddr = {4{4'd3}};
    read = 1'b1;
    tick();
    clkena = 1'b0;
    raddr = {4{4'd4}};
    for (int s = 0; s < 2; s++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (rdval_w[d] !== 1'b0) begin
          n_err++;
          $display("FAIL stall_val dut%0d stall%0d: got %b want 0", d, s, rdval_w[d]);
        end
      end
    end
    read = 1'b0;
    clkena = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rdval_w[d] !== 1'b1 || rdat_w[d] !== 32'h13121110) begin
        n_err++;
        $display("FAIL stall_out dut%0d: val=%b dat=%h want 1/13121110", d, rdval_w[d], rdat_w[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rdval_w[d] !== 1'b0) begin
        n_err++;
        $display("FAIL stall_spurious dut%0d: got %b want 0", d, rdval_w[d]);
      end
    end
  endtask

  task automatic test_collision();
    wr_all(4'd5, 32'h55555555);
    write = 4'hF; waddr = {4{4'd5}}; wdat = 32'hAAAAAAAA;
    raddr = {4{4'd5}}; read = 1'b1;
    tick();
    n_vec++;
    if (rdval_w[2] !== 1'b1 || rdat_w[2] !== 32'h55555555) begin
      n_err++;
      $display("FAIL collision_l1: val=%b dat=%h want 1/55555555", rdval_w[2], rdat_w[2]);
    end
    write = 4'h0;
    tick();
    n_vec++;
    if (rdval_w[0] !== 1'b1 || rdat_w[0] !== 32'h55555555) begin
      n_err++;
      $display("FAIL collision_old: val=%b dat=%h want 1/55555555", rdval_w[0], rdat_w[0]);
    end
    n_vec++;
    if (rdval_w[1] !== 1'b1 || rdat_w[1] !== 32'hAAAAAAAA) begin
      n_err++;
      $display("FAIL collision_fwd: val=%b dat=%h want 1/aaaaaaaa", rdval_w[1], rdat_w[1]);
    end
    read = 1'b0;
    write = 4'hF; wdat = 32'hCCCCCCCC;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rdval_w[d] !== 1'b1 || rdat_w[d] !== 32'hAAAAAAAA) begin
        n_err++;
        $display("FAIL collision_follow dut%0d: val=%b dat=%h want 1/aaaaaaaa", d, rdval_w[d], rdat_w[d]);
      end
    end
    write = 4'h0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rdval_w[d] !== 1'b0) begin
        n_err++;
        $display("FAIL collision_idle dut%0d: got %b want 0", d, rdval_w[d]);
      end
    end
  endtask

  task automatic test_latency_sweep();
    for (int a = 0; a < 16; a++) wr_all(4'(a), pat_word(a));
    for (int t = 0; t < 20; t++) begin
      if (t < 16) begin
        raddr = {4{4'(t)}};
        read = 1'b1;
      end else begin
        read = 1'b0;
      end
      tick();
      for (int d = 0; d < ND; d++) begin
        int idx;
        logic exp_v;
        idx = t - (lat(d) - 1);
        exp_v = (idx >= 0 && idx < 16);
        n_vec++;
        if (rdval_w[d] !== exp_v) begin
          n_err++;
          $display("FAIL sweep_val dut%0d t%0d: got %b want %b", d, t, rdval_w[d], exp_v);
        end
        if (exp_v) begin
          n_vec++;
          if (rdat_w[d] !== pat_word(idx)) begin
            n_err++;
            $display("FAIL sweep_dat dut%0d addr%0d: got %h want %h", d, idx, rdat_w[d], pat_word(idx));
          end
        end
      end
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int a = 0; a < 16; a++) wr_all(4'(a), 32'hFFFFFFFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    busy_cnt = (busy_w[0] === 1'b1) ? 1 : 0;
    write = 4'hF; wdat = 32'h77777777; read = 1'b1;
    for (int t = 0; t < 40 && busy_w[0] === 1'b1; t++) begin
      waddr = {4{4'(t)}};
      raddr = {4{4'(t)}};
      clear = (t == 5);
      tick();
      for (int d = 0; d < ND; d++) begin
        n_vec++;
        if (rdval_w[d] !== 1'b0) begin
          n_err++;
          $display("FAIL clear_masked dut%0d t%0d: got %b want 0", d, t, rdval_w[d]);
        end
      end
      if (busy_w[0] === 1'b1) busy_cnt++;
    end
    write = 4'h0; read = 1'b0; clear = 1'b0;
    n_vec++;
    if (busy_cnt != 16) begin
      n_err++;
      $display("FAIL clear_len: busy for %0d cycles, want 16", busy_cnt);
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      for (int d = 0; d < ND; d++) begin
        n_vec++;
        if (rdval_w[d] !== 1'b0 || busy_w[d] !== 1'b0) begin
          n_err++;
          $display("FAIL clear_tail dut%0d: val=%b busy=%b want 0/0", d, rdval_w[d], busy_w[d]);
        end
      end
    end
    for (int t = 0; t < 20; t++) begin
      if (t < 16) begin
        raddr = {4{4'(t)}};
        read = 1'b1;
      end else begin
        read = 1'b0;
      end
      tick();
      for (int d = 0; d < ND; d++) begin
        int idx;
        idx = t - (lat(d) - 1);
        if (idx >= 0 && idx < 16) begin
          n_vec++;
          if (rdval_w[d] !== 1'b1 || rdat_w[d] !== 32'h0) begin
            n_err++;
            $display("FAIL clear_zero dut%0d addr%0d: val=%b dat=%h want 1/00000000", d, idx, rdval_w[d], rdat_w[d]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cnt;
    wr_all(4'd9, 32'h99999999);
    raddr = {4{4'd9}};
    read = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    n_vec++;
    if (busy_w[0] !== 1'b1 || rdat_w[0] !== 32'h99999999) begin
      n_err++;
      $display("FAIL midsweep_pre: busy=%b dat=%h want 1/99999999", busy_w[0], rdat_w[0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      n_vec++;
      if (busy_w[d] !== 1'b0 || rdval_w[d] !== 1'b0 || rdat_w[d] !== 32'h0) begin
        n_err++;
        $display("FAIL midsweep_reset dut%0d: busy=%b val=%b dat=%h want 0/0/0", d, busy_w[d], rdval_w[d], rdat_w[d]);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    busy_cnt = (busy_w[0] === 1'b1) ? 1 : 0;
    for (int t = 0; t < 40 && busy_w[0] === 1'b1; t++) begin
      tick();
      if (busy_w[0] === 1'b1) busy_cnt++;
    end
    n_vec++;
    if (busy_cnt != 16) begin
      n_err++;
      $display("FAIL midsweep_len: busy for %0d cycles, want 16", busy_cnt);
    end
    wr_all(4'd2, 32'h5A5A5A5A);
    raddr = {4{4'd2}}; read = 1'b1;
    tick();
    raddr = {4{4'd9}};
    tick();
    read = 1'b0;
    n_vec++;
    if (rdval_w[0] !== 1'b1 || rdat_w[0] !== 32'h5A5A5A5A) begin
      n_err++;
      $display("FAIL first_write: val=%b dat=%h want 1/5a5a5a5a", rdval_w[0], rdat_w[0]);
    end
    tick();
    n_vec++;
    if (rdval_w[0] !== 1'b1 || rdat_w[0] !== 32'h0) begin
      n_err++;
      $display("FAIL resweep_zero: val=%b dat=%h want 1/00000000", rdval_w[0], rdat_w[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_latency();
    test_clkena_stall();
    test_collision();
    test_latency_sweep();
    test_clear();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
